// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: condition codes, branch kinds and
// bit positions inside the NZCV flag word.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001,
        HS = 4'b0010, LO = 4'b0011,
        MI = 4'b0100, PL = 4'b0101,
        VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001,
        GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101,
        AL = 4'b1110, NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_COND   = 2'b01,
        BR_CBZ    = 2'b10,
        BR_UNCOND = 2'b11
    } br_type_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against a stored NZCV word.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = nzcv[N_BIT];
    assign z_flag = nzcv[Z_BIT];
    assign c_flag = nzcv[C_BIT];
    assign v_flag = nzcv[V_BIT];

    always_comb begin
        pass = 1'b1;
        unique case (cond_e'(cond))
            EQ: pass = z_flag;
            NE: pass = ~z_flag;
            HS: pass = c_flag;
            LO: pass = ~c_flag;
            MI: pass = n_flag;
            PL: pass = ~n_flag;
            VS: pass = v_flag;
            VC: pass = ~v_flag;
            HI: pass = c_flag & ~z_flag;
            LS: pass = ~c_flag | z_flag;
            GE: pass = (n_flag == v_flag);
            LT: pass = (n_flag != v_flag);
            GT: pass = ~z_flag & (n_flag == v_flag);
            LE: pass = z_flag | (n_flag != v_flag);
            AL: pass = 1'b1;
            NV: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM boundary register with the architectural NZCV register and the
// branch decision for B, B.cond and CBZ.
module ex_flag_stage
    import cpu_pkg::*;
#(
    parameter int LENGTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LENGTH-1:0] alu_out,
    input  logic              negative,
    input  logic              zero,
    input  logic              overflow,
    input  logic              carry_flag,
    input  logic              in_valid,
    input  logic              set_flags,
    input  logic [1:0]        br_type,
    input  logic [3:0]        cond,
    input  logic              stall,
    input  logic              flush,
    output logic [LENGTH-1:0] mem_result,
    output logic              mem_valid,
    output logic              mem_branch_taken,
    output logic [3:0]        nzcv
);

    logic [LENGTH-1:0] mem_result_reg;
    logic              mem_valid_reg;
    logic              mem_branch_taken_reg;
    logic [3:0]        nzcv_reg;
    logic [3:0]        nzcv_next;
    logic              cond_pass;
    logic              taken;
    logic              fire;

    assign fire = in_valid & ~stall & ~flush;

    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (nzcv_reg),
        .pass (cond_pass)
    );

    // CBZ relies on the ALU passing the tested register through, so the live
    // zero flag is the comparison result.
    always_comb begin
        taken = 1'b0;
        unique case (br_type_e'(br_type))
            BR_NONE:   taken = 1'b0;
            BR_COND:   taken = cond_pass;
            BR_CBZ:    taken = zero;
            BR_UNCOND: taken = 1'b1;
        endcase
    end

    always_comb begin
        nzcv_next = nzcv_reg;
        if (fire && set_flags) begin
            nzcv_next = {negative, zero, carry_flag, overflow};
        end
    end

    // Flush has priority over stall; the result word is left as-is on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_result_reg       <= '0;
            mem_valid_reg        <= 1'b0;
            mem_branch_taken_reg <= 1'b0;
        end else if (flush) begin
            mem_valid_reg        <= 1'b0;
            mem_branch_taken_reg <= 1'b0;
        end else if (!stall) begin
            mem_result_reg       <= alu_out;
            mem_valid_reg        <= in_valid;
            mem_branch_taken_reg <= taken & in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_reg <= 4'b0000;
        end else begin
            nzcv_reg <= nzcv_next;
        end
    end

    assign mem_result       = mem_result_reg;
    assign mem_valid        = mem_valid_reg;
    assign mem_branch_taken = mem_branch_taken_reg;
    assign nzcv             = nzcv_reg;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed scenarios plus random
// traffic scored against a behavioural model of the stage.
module tb_ex_flag_stage;

    localparam int LENGTH = 64;

    logic              clk;
    logic              reset_n;
    logic [LENGTH-1:0] alu_out;
    logic              negative;
    logic              zero;
    logic              overflow;
    logic              carry_flag;
    logic              in_valid;
    logic              set_flags;
    logic [1:0]        br_type;
    logic [3:0]        cond;
    logic              stall;
    logic              flush;
    logic [LENGTH-1:0] mem_result;
    logic              mem_valid;
    logic              mem_branch_taken;
    logic [3:0]        nzcv;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [LENGTH-1:0] exp_result;
    logic              exp_valid;
    logic              exp_taken;
    logic [3:0]        exp_nzcv;

    ex_flag_stage #(.LENGTH(LENGTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_out          (alu_out),
        .negative         (negative),
        .zero             (zero),
        .overflow         (overflow),
        .carry_flag       (carry_flag),
        .in_valid         (in_valid),
        .set_flags        (set_flags),
        .br_type          (br_type),
        .cond             (cond),
        .stall            (stall),
        .flush            (flush),
        .mem_result       (mem_result),
        .mem_valid        (mem_valid),
        .mem_branch_taken (mem_branch_taken),
        .nzcv             (nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ARM semantics: cond[3:1] picks a base test, cond[0] inverts it except for 111x.
    function automatic logic cond_holds(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cd[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (cd[0] && cd[3:1] != 3'd7) ? !base : base;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".result"}, mem_result, exp_result);
        check({tag, ".valid"},  64'(mem_valid), 64'(exp_valid));
        check({tag, ".taken"},  64'(mem_branch_taken), 64'(exp_taken));
        check({tag, ".nzcv"},   64'(nzcv), 64'(exp_nzcv));
    endtask

    // One clock of stimulus: drive, let the model predict, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic v, input logic sf, input logic st,
                        input logic fl, input logic [1:0] bt, input logic [3:0] cd,
                        input logic [63:0] a, input logic [3:0] flags);
        logic want_taken;
        in_valid = v; set_flags = sf; stall = st; flush = fl;
        br_type = bt; cond = cd; alu_out = a;
        {negative, zero, carry_flag, overflow} = flags;
        case (bt)
            2'b00:   want_taken = 1'b0;
            2'b11:   want_taken = 1'b1;
            2'b10:   want_taken = flags[2];
            default: want_taken = cond_holds(cd, exp_nzcv);
        endcase
        @(posedge clk);
        #1;
        if (fl) begin
            exp_valid = 1'b0;
            exp_taken = 1'b0;
        end else if (!st) begin
            exp_result = a;
            exp_valid  = v;
            exp_taken  = want_taken && v;
        end
        if (v && !st && !fl && sf) exp_nzcv = flags;
        txn++;
        $display("txn %0d %s v=%0b sf=%0b st=%0b fl=%0b bt=%0d cond=%0d -> valid=%0b taken=%0b nzcv=%b result=%0h",
                 txn, tag, v, sf, st, fl, bt, cd, mem_valid, mem_branch_taken, nzcv, mem_result);
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_result = '0; exp_valid = 1'b0; exp_taken = 1'b0; exp_nzcv = 4'b0000;
    endtask

    logic [3:0] sweep_flags [4];

    initial begin
        sweep_flags[0] = 4'b1000; sweep_flags[1] = 4'b0001;
        sweep_flags[2] = 4'b1001; sweep_flags[3] = 4'b0100;

        reset_n = 1'b0; in_valid = 1'b1; set_flags = 1'b1; stall = 1'b0; flush = 1'b0;
        br_type = 2'b11; cond = 4'h0; alu_out = 64'd5;
        {negative, zero, carry_flag, overflow} = 4'b1111;
        model_reset();
        #3;
        check_all("reset_async");
        @(posedge clk); #1;
        check_all("reset_held");
        @(negedge clk);
        reset_n = 1'b1;

        step("load9", 1, 0, 0, 0, 2'b00, 4'h0, 64'd9, 4'b0000);
        check("load9_const", mem_result, 64'd9);

        // SUBS giving Z=1 C=1, then dependent B.cond
        step("subs", 1, 1, 0, 0, 2'b00, 4'h0, 64'd0, 4'b0110);
        check("subs_nzcv_const", 64'(nzcv), 64'(4'b0110));
        step("beq", 1, 0, 0, 0, 2'b01, 4'h0, 64'd1, 4'b0000);
        check("beq_const", 64'(mem_branch_taken), 64'd1);
        step("bne", 1, 0, 0, 0, 2'b01, 4'h1, 64'd2, 4'b0000);
        check("bne_const", 64'(mem_branch_taken), 64'd0);
        // Setter that is also a B.cond sees the old flags (Z=1 -> EQ taken)
        step("subs_beq", 1, 1, 0, 0, 2'b01, 4'h0, 64'd3, 4'b0000);
        check("subs_beq_const", 64'(mem_branch_taken), 64'd1);

        foreach (sweep_flags[i]) begin
            step("setf", 1, 1, 0, 0, 2'b00, 4'h0, 64'(i), sweep_flags[i]);
            for (int c = 0; c < 16; c++)
                step("sweep", 1, 0, 0, 0, 2'b01, 4'(c), 64'(c + 100), 4'b0000);
        end

        step("cbz_zero", 1, 0, 0, 0, 2'b10, 4'h0, 64'd0, 4'b0100);
        check("cbz_zero_const", 64'(mem_branch_taken), 64'd1);
        step("cbz_nz", 1, 0, 0, 0, 2'b10, 4'h0, 64'd3, 4'b0000);
        check("cbz_nz_const", 64'(mem_branch_taken), 64'd0);
        step("b_uncond", 1, 0, 0, 0, 2'b11, 4'h0, 64'd7, 4'b0000);

        for (int k = 0; k < 3; k++)
            step("stall", 1, 1, 1, 0, 2'b11, 4'h0, 64'hdead, 4'b1111);
        step("stall_flush", 1, 1, 1, 1, 2'b11, 4'h0, 64'hbeef, 4'b1111);
        check("stall_flush_valid_const", 64'(mem_valid), 64'd0);
        step("flush_sf", 1, 1, 0, 1, 2'b11, 4'h0, 64'h55, 4'b1010);
        step("bubble", 0, 1, 0, 0, 2'b11, 4'h0, 64'h66, 4'b0100);
        check("bubble_valid_const", 64'(mem_valid), 64'd0);

        for (int k = 0; k < 300; k++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 6) == 0), 2'($urandom), 4'($urandom),
                 {$urandom, $urandom}, 4'($urandom));
        end

        // Reset asserted mid-cycle during a stall must clear everything at once
        in_valid = 1'b1; stall = 1'b1; alu_out = 64'd5;
        @(posedge clk); #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_mid_stall");
        @(negedge clk);
        reset_n = 1'b1; stall = 1'b0;
        step("post_reset", 1, 0, 0, 0, 2'b00, 4'h0, 64'd9, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-to-memory boundary stage placed directly downstream of the ALU (including its pass-through/buffer operation). It registers the ALU result into the EX/MEM pipeline register and keeps the architectural NZCV flag register. It resolves B, B.cond and CBZ branch decisions from the ALU's live zero flag or the stored NZCV. Stall and flush inputs from the hazard unit control capture.

## Interface
Parameters:
- LENGTH, 64, datapath width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_out  in  LENGTH  ALU result for the instruction in EX
- negative, zero, overflow, carry_flag  in  1 each  ALU flags for the same instruction
- in_valid  in  1  EX holds a real instruction
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS class)
- br_type  in  2  00 none, 01 B.cond, 10 CBZ, 11 B (unconditional)
- cond  in  4  ARM condition field, used when br_type=01
- stall  in  1  hold all state
- flush  in  1  kill the instruction in EX
- mem_result  out  LENGTH  registered ALU result
- mem_valid  out  1  registered valid
- mem_branch_taken  out  1  registered branch decision
- nzcv  out  4  architectural flags {N,Z,C,V}

## Operation
- fire = in_valid & ~stall & ~flush.
- EX/MEM register, per clock edge:
  - flush=1: mem_valid←0, mem_branch_taken←0, mem_result unchanged. Flush wins over stall.
  - else stall=1: all registers hold.
  - else: mem_result←alu_out, mem_valid←in_valid, mem_branch_taken←taken & in_valid.
- NZCV register: on fire & set_flags, nzcv←{negative, zero, carry_flag, overflow}; otherwise hold.
- taken is combinational, evaluated in EX:
  - br_type 00: 0.
  - br_type 11: 1.
  - br_type 10 (CBZ): the live `zero` input. The ALU passes B through, so zero reflects the tested register.
  - br_type 01: cond evaluated against the current nzcv register output.
- No intra-stage forwarding. A flag setter updates nzcv at the edge on which it leaves EX, so the following instruction already sees the new value. set_flags together with br_type=01 in one instruction evaluates against the old nzcv.
- Condition codes:
  - EQ 0000 Z; NE 0001 ~Z
  - HS 0010 C; LO 0011 ~C
  - MI 0100 N; PL 0101 ~N
  - VS 0110 V; VC 0111 ~V
  - HI 1000 C&~Z; LS 1001 ~C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V)
  - 1110 and 1111 always true.

## Timing
- Latency one cycle: EX inputs at edge k appear on mem_* after edge k.
- nzcv is visible the cycle after the setting edge.
- Reset (asynchronous, any time including mid-stall): mem_result=0, mem_valid=0, mem_branch_taken=0, nzcv=4'b0000. Takes effect immediately, no clock needed.
- in_valid=0 with neither stall nor flush: a bubble is captured (mem_valid=0, taken=0) and nzcv does not change.
- Stall lasting N cycles: outputs stay constant for N edges and nzcv is not written even if set_flags=1. The instruction is re-presented after the stall.
- flush and set_flags in the same cycle: nzcv is not written.

## Structure
- Package cpu_pkg holds:
  - cond_e enum (EQ…NV)
  - br_type_e enum
  - NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0
- Sub-module cond_eval: combinational, inputs cond[3:0] and nzcv[3:0], output pass. Instantiated once.

## Test plan
- Reset: hold reset_n=0 mid-cycle with alu_out=5 -> all outputs 0 immediately. Release, then in_valid=1, alu_out=64'd9 -> mem_result=9, mem_valid=1 one edge later.
- Flag write then branch:
  - SUBS producing zero=1, carry_flag=1 -> nzcv=0110.
  - Next cycle B.cond EQ -> mem_branch_taken=1. B.cond NE -> 0.
- Every cond code: sweep all 16 codes against nzcv values 1000, 0001, 1001, 0100; mem_branch_taken must match the table above, including GE/LT with N=V=1.
- CBZ:
  - alu_out=0, zero=1, br_type=10 -> taken=1, nzcv unchanged.
  - alu_out=64'd3, zero=0 -> taken=0.
- Stall/flush:
  - stall=1 for 3 cycles with set_flags=1 -> outputs and nzcv frozen.
  - stall=1 with flush=1 -> mem_valid=0 next edge, nzcv unchanged.
- Bubble: in_valid=0, set_flags=1, zero=1 -> mem_valid=0, nzcv unchanged.
